tpu_seq_ctrl: RTL and testbench
===============================

# tpu_seq_ctrl

Sequencer between the host-pin opcode decoder and the systolic array datapath. It turns decoded fetch/start strobes into buffer write enables and tracks which weight and input entries are loaded. On an accepted start it runs the fixed LOAD_W → FEED → DRAIN sequence that drives the N×N array, then reports completion. It owns no storage except a valid bitmap, the instruction register and the sequencing counters.

## Interface
- `N`, default 2: array dimension. The weight and input buffers each hold N*N bytes.
- `DATA_W`, default 8: data byte width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `fetch_w`, `fetch_inp`, `fetch_ins`, `start`  in  1 each  level strobes from the opcode decoder; at most one is high at a time.
- `dma_address`  in  4  buffer address accompanying a fetch.
- `ui_in`  in  DATA_W  data byte accompanying a fetch.
- `wbuf_we`, `ibuf_we`  out  1  weight / input buffer write enable (registered).
- `buf_waddr`  out  4  write address (registered).
- `buf_wdata`  out  DATA_W  write data (registered).
- `instr`  out  DATA_W  instruction register, written by `fetch_ins` at address 0.
- `arr_load_w`  out  1  array weight-load phase.
- `arr_feed`  out  1  array input-feed phase.
- `rd_row`  out  $clog2(N)  weight row being loaded.
- `feed_step`  out  $clog2(2N)  feed cycle index.
- `busy`, `done`, `err`  out  1  status.

## Operation
- Reset values:
  - All outputs are 0.
  - Valid bitmaps are cleared; state is IDLE.
- States: IDLE, LOAD_W, FEED, DRAIN, DONE.
- Writes are accepted in IDLE and DONE only. Each cycle with a strobe high writes again; repeated writes to the same address are idempotent.
  - `fetch_w` with addr < N*N: on the next edge, `wbuf_we`=1, addr/data registered, and `w_valid[addr]` is set.
  - `fetch_inp` behaves the same way, using `ibuf_we` and `i_valid`.
  - `fetch_ins` with addr = 0: `instr` ← `ui_in`. Any other addr is ignored and sets `err`.
  - A weight or input addr ≥ N*N: no write enable, and `err` is set.
  - Any fetch while `busy`: ignored, and `err` is set.
- Start handling:
  - `start` is rising-edge detected against a registered copy.
  - An edge in IDLE or DONE with both bitmaps all-ones is accepted: `err` clears, `done` clears, and the state moves to LOAD_W.
  - An edge with an incomplete bitmap is rejected: state unchanged, `err` set.
  - An edge while `busy` is ignored without setting `err`.
- Sequence:
  - LOAD_W, N cycles: `arr_load_w`=1 and `rd_row` counts 0..N-1.
  - FEED, 2N-1 cycles: `arr_feed`=1 and `feed_step` counts 0..2N-2.
  - DRAIN, N cycles: neither array control is high.
  - DONE: `done`=1 and held.
- `busy`=1 exactly in LOAD_W, FEED and DRAIN.
- Bitmaps are not cleared by a run, so a re-start without reloading is legal.
- Any fetch accepted in DONE clears `done` and returns the state to IDLE.
- `err` is sticky. It clears only on reset or on an accepted start.

## Timing
- All outputs are registered.
- Write latency: strobe sampled at edge k → `wbuf_we`/`ibuf_we` high during cycle k+1.
- Start sampled at edge t:
  - `busy` and `arr_load_w` are high from t+1.
  - `arr_feed` is high for cycles t+1+N .. t+3N-1.
  - `done` rises at t+4N (t+8 for N=2).
- A start edge on the same edge as the final bitmap write is rejected, because the bitmap is checked before the update.
- A reset mid-sequence returns to IDLE immediately and clears the bitmaps, `instr`, counters and status.
- Counter wrap: `rd_row`/`feed_step` return to 0 on phase exit and never wrap within a phase.

## Structure
- `tpu_pkg` holds:
  - the state enum `seq_state_t`;
  - the phase-length localparams (LOAD_LEN=N, FEED_LEN=2N-1, DRAIN_LEN=N);
  - the opcode constants shared with the decoder.
- Natural sub-module: `seq_fsm`, containing the state register, phase counter and start edge detect. The write/bitmap logic stays in the top level.

## Test plan
- Reset, then write weights 0x11,0x22,0x33,0x44 to addr 0..3 and inputs to addr 0..3 → `wbuf_we`/`ibuf_we` each pulse four times one cycle after each strobe, `buf_wdata` matches, `err`=0.
- Full load, start held high 5 cycles → one run only:
  - `arr_load_w` high 2 cycles;
  - `arr_feed` high 3 cycles, `feed_step` 0,1,2;
  - `done` 8 cycles after the start sample.
- Only 3 weights written, then start → state stays IDLE, `err`=1. Write addr 3, start again → run proceeds and `err` clears.
- `fetch_w` addr 5 (N=2) → no `wbuf_we`, `err`=1. `fetch_ins` addr 0 data 0xA5 → `instr`=0xA5.
- `fetch_inp` during FEED → no `ibuf_we`, `err`=1, and the sequence timing is unchanged.
- Reset asserted during FEED → all outputs 0 immediately. A subsequent start without reloading is rejected with `err`=1.

Source files
------------

// File: rtl/tpu_pkg.sv
//------------------------------------------------------------------------------
// Module  : tpu_pkg
// Brief   : Shared types and constants for the TPU sequencer and opcode decoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package tpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

  localparam int ARR_N     = 2;
  localparam int LOAD_LEN  = ARR_N;
  localparam int FEED_LEN  = 2 * ARR_N - 1;
  localparam int DRAIN_LEN = ARR_N;

  localparam logic [1:0] OP_FETCH_W   = 2'd0;
  localparam logic [1:0] OP_FETCH_INP = 2'd1;
  localparam logic [1:0] OP_FETCH_INS = 2'd2;
  localparam logic [1:0] OP_START     = 2'd3;

  // Phase lengths for an arbitrary array size.
  function automatic int load_len(input int n);
    return n;
  endfunction

  function automatic int feed_len(input int n);
    return 2 * n - 1;
  endfunction

  function automatic int drain_len(input int n);
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_fsm.sv
//------------------------------------------------------------------------------
// Module  : seq_fsm
// Brief   : Start edge detect, state register and phase counter for LOAD_W/FEED/DRAIN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_fsm
  import tpu_pkg::*;
#(
  parameter int N = ARR_N
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      bitmap_full,
  input  logic                      fetch_accept,
  output logic                      start_accept,
  output logic                      start_reject,
  output logic                      busy,
  output logic                      done,
  output logic                      arr_load_w,
  output logic                      arr_feed,
  output logic [$clog2(N)-1:0]      rd_row,
  output logic [$clog2(2*N)-1:0]    feed_step
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] C_LOAD_LAST  = CW'(load_len(N) - 1);
  localparam logic [CW-1:0] C_FEED_LAST  = CW'(feed_len(N) - 1);
  localparam logic [CW-1:0] C_DRAIN_LAST = CW'(drain_len(N) - 1);

  seq_state_t                 r_state;
  logic [CW-1:0]              r_cnt;
  logic                       r_start_q;
  logic                       r_busy;
  logic                       r_done;
  logic                       r_load_w;
  logic                       r_feed;
  logic [$clog2(N)-1:0]       r_rd_row;
  logic [CW-1:0]              r_feed_step;

  logic w_rise;
  logic w_open;

  assign w_rise       = start & ~r_start_q;
  assign w_open       = (r_state == S_IDLE) || (r_state == S_DONE);
  assign start_accept = w_rise & w_open & bitmap_full;
  assign start_reject = w_rise & w_open & ~bitmap_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_start_q   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_w    <= 1'b0;
      r_feed      <= 1'b0;
      r_rd_row    <= '0;
      r_feed_step <= '0;
    end else begin
      r_start_q <= start;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_accept) begin
            r_state  <= S_LOAD_W;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
            r_load_w <= 1'b1;
            r_rd_row <= '0;
          end else if (fetch_accept && r_state == S_DONE) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
        end
        S_LOAD_W: begin
          if (r_cnt == C_LOAD_LAST) begin
            r_state     <= S_FEED;
            r_cnt       <= '0;
            r_load_w    <= 1'b0;
            r_rd_row    <= '0;
            r_feed      <= 1'b1;
            r_feed_step <= '0;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
            r_rd_row <= r_rd_row + 1'b1;
          end
        end
        S_FEED: begin
          if (r_cnt == C_FEED_LAST) begin
            r_state     <= S_DRAIN;
            r_cnt       <= '0;
            r_feed      <= 1'b0;
            r_feed_step <= '0;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_feed_step <= r_feed_step + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_cnt == C_DRAIN_LAST) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_cnt    <= '0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
          r_load_w <= 1'b0;
          r_feed   <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign arr_load_w = r_load_w;
  assign arr_feed   = r_feed;
  assign rd_row     = r_rd_row;
  assign feed_step  = r_feed_step;

endmodule

`default_nettype wire

// File: rtl/tpu_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tpu_seq_ctrl
// Brief   : Buffer write steering, valid bitmaps, instruction register and run sequencer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tpu_seq_ctrl
  import tpu_pkg::*;
#(
  parameter int N      = ARR_N,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fetch_w,
  input  logic                      fetch_inp,
  input  logic                      fetch_ins,
  input  logic                      start,
  input  logic [3:0]                dma_address,
  input  logic [DATA_W-1:0]         ui_in,
  output logic                      wbuf_we,
  output logic                      ibuf_we,
  output logic [3:0]                buf_waddr,
  output logic [DATA_W-1:0]         buf_wdata,
  output logic [DATA_W-1:0]         instr,
  output logic                      arr_load_w,
  output logic                      arr_feed,
  output logic [$clog2(N)-1:0]      rd_row,
  output logic [$clog2(2*N)-1:0]    feed_step,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int NN = N * N;
  localparam logic [NN-1:0] C_ALL_VALID = '1;

  logic [NN-1:0]      r_w_valid;
  logic [NN-1:0]      r_i_valid;
  logic               r_wbuf_we;
  logic               r_ibuf_we;
  logic [3:0]         r_waddr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_instr;
  logic               r_err;

  logic               w_full;
  logic               w_addr_ok;
  logic               w_wr_w;
  logic               w_wr_i;
  logic               w_wr_ins;
  logic               w_fetch_accept;
  logic               w_fetch_err;
  logic               w_start_accept;
  logic               w_start_reject;
  logic [NN-1:0]      w_addr_mask;

  // Bitmap completeness uses pre-edge contents, so a start cannot race a final write.
  assign w_full         = (r_w_valid == C_ALL_VALID) && (r_i_valid == C_ALL_VALID);
  assign w_addr_ok      = ({28'd0, dma_address} < NN);
  assign w_addr_mask    = NN'(1) << dma_address;
  assign w_wr_w         = fetch_w   & ~busy & w_addr_ok;
  assign w_wr_i         = fetch_inp & ~busy & w_addr_ok;
  assign w_wr_ins       = fetch_ins & ~busy & (dma_address == 4'd0);
  assign w_fetch_accept = w_wr_w | w_wr_i | w_wr_ins;
  assign w_fetch_err    = (fetch_w | fetch_inp | fetch_ins) & ~w_fetch_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_w_valid <= '0;
      r_i_valid <= '0;
      r_wbuf_we <= 1'b0;
      r_ibuf_we <= 1'b0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_instr   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wbuf_we <= w_wr_w;
      r_ibuf_we <= w_wr_i;
      if (w_wr_w || w_wr_i) begin
        r_waddr <= dma_address;
        r_wdata <= ui_in;
      end
      if (w_wr_w) r_w_valid <= r_w_valid | w_addr_mask;
      if (w_wr_i) r_i_valid <= r_i_valid | w_addr_mask;
      if (w_wr_ins) r_instr <= ui_in;
      if (w_start_accept)
        r_err <= 1'b0;
      else if (w_fetch_err || w_start_reject)
        r_err <= 1'b1;
    end
  end

  seq_fsm #(
    .N (N)
  ) u_seq_fsm (
    .clk          (clk),
    .rst          (reset),
    .start        (start),
    .bitmap_full  (w_full),
    .fetch_accept (w_fetch_accept),
    .start_accept (w_start_accept),
    .start_reject (w_start_reject),
    .busy         (busy),
    .done         (done),
    .arr_load_w   (arr_load_w),
    .arr_feed     (arr_feed),
    .rd_row       (rd_row),
    .feed_step    (feed_step)
  );

  assign wbuf_we   = r_wbuf_we;
  assign ibuf_we   = r_ibuf_we;
  assign buf_waddr = r_waddr;
  assign buf_wdata = r_wdata;
  assign instr     = r_instr;
  assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_tpu_seq_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_tpu_seq_ctrl
// Brief   : Self-checking bench for tpu_seq_ctrl against a run-age reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tpu_seq_ctrl;

  localparam int N   = 2;
  localparam int DW  = 8;
  localparam int NN  = N * N;
  localparam int RUN = 4 * N;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   fetch_w, fetch_inp, fetch_ins, start;
  logic [3:0]             dma_address;
  logic [DW-1:0]          ui_in;
  logic                   wbuf_we, ibuf_we;
  logic [3:0]             buf_waddr;
  logic [DW-1:0]          buf_wdata, instr;
  logic                   arr_load_w, arr_feed;
  logic [$clog2(N)-1:0]   rd_row;
  logic [$clog2(2*N)-1:0] feed_step;
  logic                   busy, done, err;

  tpu_seq_ctrl #(.N(N), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .fetch_w(fetch_w), .fetch_inp(fetch_inp), .fetch_ins(fetch_ins), .start(start),
    .dma_address(dma_address), .ui_in(ui_in),
    .wbuf_we(wbuf_we), .ibuf_we(ibuf_we), .buf_waddr(buf_waddr), .buf_wdata(buf_wdata),
    .instr(instr), .arr_load_w(arr_load_w), .arr_feed(arr_feed),
    .rd_row(rd_row), .feed_step(feed_step), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: run progress is a plain age count since the accepted start.
  int m_wv, m_iv, m_instr, m_err, m_done, m_running, m_age, m_start_prev;
  int m_wbuf_we, m_ibuf_we, m_waddr, m_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wv = 0; m_iv = 0; m_instr = 0; m_err = 0; m_done = 0;
    m_running = 0; m_age = 0; m_start_prev = 0;
    m_wbuf_we = 0; m_ibuf_we = 0; m_waddr = 0; m_wdata = 0;
  endtask

  task automatic model_edge();
    int full, rise, acc, a;
    full = (m_wv == (1 << NN) - 1) && (m_iv == (1 << NN) - 1);
    rise = start && !m_start_prev;
    m_start_prev = start;
    a = dma_address;
    acc = 0;
    m_wbuf_we = 0;
    m_ibuf_we = 0;
    if (fetch_w || fetch_inp || fetch_ins) begin
      if (m_running) m_err = 1;
      else if (fetch_ins) begin
        if (a == 0) begin m_instr = ui_in; acc = 1; end
        else m_err = 1;
      end else if (a < NN) begin
        acc = 1;
        m_waddr = a;
        m_wdata = ui_in;
        if (fetch_w) begin m_wbuf_we = 1; m_wv |= (1 << a); end
        else begin m_ibuf_we = 1; m_iv |= (1 << a); end
      end else m_err = 1;
      if (acc) m_done = 0;
    end
    if (rise && !m_running) begin
      if (full) begin m_running = 1; m_age = 0; m_err = 0; m_done = 0; end
      else m_err = 1;
    end
    if (m_running) begin
      m_age++;
      if (m_age == RUN) begin m_running = 0; m_done = 1; end
    end
  endtask

  task automatic check_all();
    int ld, fd;
    ld = m_running && m_age <= N;
    fd = m_running && m_age >= N + 1 && m_age <= 3 * N - 1;
    check("wbuf_we",    wbuf_we,    m_wbuf_we);
    check("ibuf_we",    ibuf_we,    m_ibuf_we);
    check("buf_waddr",  buf_waddr,  m_waddr);
    check("buf_wdata",  buf_wdata,  m_wdata);
    check("instr",      instr,      m_instr);
    check("busy",       busy,       m_running);
    check("arr_load_w", arr_load_w, ld);
    check("rd_row",     rd_row,     ld ? m_age - 1 : 0);
    check("arr_feed",   arr_feed,   fd);
    check("feed_step",  feed_step,  fd ? m_age - N - 1 : 0);
    check("done",       done,       m_done);
    check("err",        err,        m_err);
  endtask

  // Called at posedge+1: drive inputs, take one edge, update model, compare.
  task automatic step(input logic fw, input logic fi, input logic fs, input logic st,
                      input logic [3:0] a, input logic [DW-1:0] d);
    fetch_w = fw; fetch_inp = fi; fetch_ins = fs; start = st;
    dma_address = a; ui_in = d;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, 8'h00);
  endtask

  task automatic do_reset();
    fetch_w = 0; fetch_inp = 0; fetch_ins = 0; start = 0;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic load_all();
    for (int i = 0; i < NN; i++) step(1, 0, 0, 0, 4'(i), 8'(8'h11 * (i + 1)));
    for (int i = 0; i < NN; i++) step(0, 1, 0, 0, 4'(i), 8'($urandom));
  endtask

  initial begin
    int op;
    fetch_w = 0; fetch_inp = 0; fetch_ins = 0; start = 0;
    dma_address = 0; ui_in = 0; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    load_all();
    idle(2);

    // Start held high for several cycles must launch exactly one run.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 4'd0, 8'h00);
    idle(RUN + 2);

    // Incomplete weight bitmap rejects the start; completing it allows the run.
    do_reset();
    for (int i = 0; i < NN - 1; i++) step(1, 0, 0, 0, 4'(i), 8'($urandom));
    for (int i = 0; i < NN; i++) step(0, 1, 0, 0, 4'(i), 8'($urandom));
    step(0, 0, 0, 1, 4'd0, 8'h00);
    idle(2);
    step(1, 0, 0, 0, 4'(NN - 1), 8'h44);
    step(0, 0, 0, 1, 4'd0, 8'h00);
    idle(RUN + 1);

    // Out-of-range weight address, then an instruction fetch out of DONE.
    step(1, 0, 0, 0, 4'd5, 8'h77);
    step(0, 0, 1, 0, 4'd0, 8'hA5);
    step(0, 0, 1, 0, 4'd3, 8'h5A);
    idle(1);

    // Input fetch during FEED is ignored and leaves the timing alone.
    step(0, 0, 0, 1, 4'd0, 8'h00);
    idle(N + 1);
    step(0, 1, 0, 0, 4'd1, 8'hEE);
    idle(RUN);

    // Reset during FEED, then a start without reloading is rejected.
    step(0, 0, 0, 1, 4'd0, 8'h00);
    idle(N + 1);
    do_reset();
    step(0, 0, 0, 1, 4'd0, 8'h00);
    idle(2);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      op = $urandom_range(0, 11);
      case (op)
        0, 1, 2: step(1, 0, 0, 0, 4'($urandom_range(0, 5)), 8'($urandom));
        3, 4, 5: step(0, 1, 0, 0, 4'($urandom_range(0, 5)), 8'($urandom));
        6:       step(0, 0, 1, 0, 4'($urandom_range(0, 1)), 8'($urandom));
        7, 8:    step(0, 0, 0, 1, 4'd0, 8'h00);
        default: step(0, 0, 0, 0, 4'($urandom), 8'($urandom));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
